regfile_write_arbiter: RTL and testbench

Shares the single register-file write port between the CPU's writeback sources (ALU result, load return, multiply/divide unit) and tracks outstanding destination writes for hazard detection. Each cycle it grants at most one valid write request by round-robin and presents it on a registered wen/waddr/wdata port that drives the register file directly. A per-register pending-write scoreboard is incremented at issue and decremented at commit, giving the issue stage a busy vector for stall decisions.

---
 rtl/regfile_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered write
// stage and a per-register pending-write scoreboard that feeds the issue stage's stalls.
module regfile_write_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned CNT_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [5*N_REQ-1:0]    req_waddr,
  input  logic [32*N_REQ-1:0]   req_wdata,
  output logic                  wen,
  output logic [4:0]            waddr,
  output logic [31:0]           wdata,
  input  logic                  issue_valid,
  input  logic [4:0]            issue_waddr,
  output logic                  issue_ready,
  output logic [31:0]           busy
);

  localparam int unsigned PtrW = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [PtrW-1:0]  gnt_idx, scan_idx;
  logic             gnt_found;
  logic [4:0]       sel_waddr;
  logic [31:0]      sel_wdata;

  logic             wen_q, wen_d;
  logic [4:0]       waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic [CNT_W-1:0] cnt_q [32];
  logic [CNT_W-1:0] cnt_d [32];
  logic [31:0]      inc_vec, dec_vec;
  logic             issue_fire;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    req_ready = '0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      scan_idx = PtrW'((int'(ptr_q) + k) % int'(N_REQ));
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    if (gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    sel_waddr = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (req_ready[i]) begin
        sel_waddr = req_waddr[5*i +: 5];
        sel_wdata = req_wdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (gnt_found) begin
      ptr_d   = (int'(gnt_idx) == int'(N_REQ) - 1) ? '0 : gnt_idx + PtrW'(1);
      // r0 writes are accepted but never reach the register file.
      wen_d   = (sel_waddr != 5'd0);
      waddr_d = sel_waddr;
      wdata_d = sel_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

  assign issue_ready = (issue_waddr == 5'd0) || (cnt_q[issue_waddr] != CntMax);
  assign issue_fire  = issue_valid && issue_ready && (issue_waddr != 5'd0);

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < 32; r++) begin
      inc_vec[r] = issue_fire && (issue_waddr == 5'(r));
      dec_vec[r] = wen_q && (waddr_q == 5'(r));
    end
  end

  // Simultaneous inc and dec cancel; a decrement of zero saturates instead of wrapping.
  always_comb begin
    busy = '0;
    for (int r = 0; r < 32; r++) begin
      cnt_d[r] = cnt_q[r];
      if (r == 0) begin
        cnt_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
      busy[r] = (r != 0) && (cnt_q[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < 32; r++) begin
      if (rst) begin
        cnt_q[r] <= '0;
      end else begin
        cnt_q[r] <= cnt_d[r];
      end
    end
  end

  // Committing a write that was never issued means the issue logic lost track.
  always_ff @(posedge clk) begin
    if (!rst && wen_q) begin
      assert (cnt_q[waddr_q] != '0)
        else $error("commit to r%0d with no pending write", waddr_q);
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against a counting/round-robin reference model.
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [14:0] req_waddr;
  logic [95:0] req_wdata;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_valid;
  logic [4:0]  issue_waddr;
  logic        issue_ready;
  logic [31:0] busy;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_write_arbiter #(.N_REQ(3), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_waddr   (req_waddr),
    .req_wdata   (req_wdata),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .issue_valid (issue_valid),
    .issue_waddr (issue_waddr),
    .issue_ready (issue_ready),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct packed {
    logic [2:0]  v;
    logic [14:0] a;
    logic [31:0] db;
    logic        iv;
    logic [4:0]  ia;
    logic [2:0]  rdy;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        eir;
    logic [31:0] eb;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [2:0] v, input logic [14:0] a, input logic [31:0] db,
                     input logic iv, input logic [4:0] ia, input logic [2:0] rdy,
                     input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                     input logic eir, input logic [31:0] eb);
    vq.push_back('{v, a, db, iv, ia, rdy, ew, ea, ed, eir, eb});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic [14:0] a, input logic [31:0] db,
                       input logic iv, input logic [4:0] ia);
    req_valid   = v;
    req_waddr   = a;
    req_wdata   = {db + 32'd2, db + 32'd1, db};
    issue_valid = iv;
    issue_waddr = ia;
  endtask

  task automatic do_reset();
    drive(3'b000, 15'h0, 32'h0, 1'b0, 5'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model state
  int          m_ptr;
  int          m_cnt [32];
  int          alloc [32];
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic        hv [3];
  logic [4:0]  ha [3];
  logic [31:0] hd [3];
  int          g, idx, r;
  logic [2:0]  exp_rdy;
  logic        exp_ir;
  logic [31:0] exp_busy;

  localparam logic [14:0] A123 = {5'd3, 5'd2, 5'd1};

  initial begin
    rst = 1'b0;
    drive(3'b000, 15'h0, 32'h0, 1'b0, 5'd0);

    //  v       a        db            iv    ia     rdy     ew    ea     ed            eir   busy
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0);
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd5,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0);
    add(3'b000, 15'h0,   32'h0,        1'b1, 5'd5,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0);
    add(3'b001, 15'd5,   32'hDEADBEEF, 1'b0, 5'd0,  3'b001, 1'b0, 5'd0,  32'h0,        1'b1, 32'h20);
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd0,  3'b000, 1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 32'h20);
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0);
    add(3'b000, 15'h0,   32'h0,        1'b1, 5'd1,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0);
    add(3'b000, 15'h0,   32'h0,        1'b1, 5'd2,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h2);
    add(3'b000, 15'h0,   32'h0,        1'b1, 5'd3,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h6);
    add(3'b000, 15'h0,   32'h0,        1'b1, 5'd1,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'hE);
    add(3'b000, 15'h0,   32'h0,        1'b1, 5'd2,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'hE);
    add(3'b000, 15'h0,   32'h0,        1'b1, 5'd3,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'hE);
    add(3'b111, A123,    32'h100,      1'b0, 5'd0,  3'b010, 1'b0, 5'd0,  32'h0,        1'b1, 32'hE);
    add(3'b111, A123,    32'h100,      1'b0, 5'd0,  3'b100, 1'b1, 5'd2,  32'h101,      1'b1, 32'hE);
    add(3'b111, A123,    32'h100,      1'b0, 5'd0,  3'b001, 1'b1, 5'd3,  32'h102,      1'b1, 32'hE);
    add(3'b111, A123,    32'h100,      1'b0, 5'd0,  3'b010, 1'b1, 5'd1,  32'h100,      1'b1, 32'hE);
    add(3'b101, A123,    32'h100,      1'b0, 5'd0,  3'b100, 1'b1, 5'd2,  32'h101,      1'b1, 32'hE);
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd0,  3'b000, 1'b1, 5'd3,  32'h102,      1'b1, 32'hA);
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h2);
    add(3'b001, 15'h0,   32'h1234,     1'b0, 5'd0,  3'b001, 1'b0, 5'd0,  32'h0,        1'b1, 32'h2);
    add(3'b011, 15'h0,   32'h0,        1'b0, 5'd0,  3'b010, 1'b0, 5'd0,  32'h0,        1'b1, 32'h2);
    add(3'b111, 15'h0,   32'h0,        1'b0, 5'd0,  3'b100, 1'b0, 5'd0,  32'h0,        1'b1, 32'h2);
    add(3'b010, 15'h0020, 32'h5000,    1'b0, 5'd0,  3'b010, 1'b0, 5'd0,  32'h0,        1'b1, 32'h2);
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd0,  3'b000, 1'b1, 5'd1,  32'h5001,     1'b1, 32'h2);
    add(3'b000, 15'h0,   32'h0,        1'b0, 5'd0,  3'b000, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0);

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].v, vq[i].a, vq[i].db, vq[i].iv, vq[i].ia);
      #1;
      chk($sformatf("vec%0d req_ready", i), 32'(req_ready), 32'(vq[i].rdy));
      chk($sformatf("vec%0d wen", i), 32'(wen), 32'(vq[i].ew));
      if (vq[i].ew) begin
        chk($sformatf("vec%0d waddr", i), 32'(waddr), 32'(vq[i].ea));
        chk($sformatf("vec%0d wdata", i), wdata, vq[i].ed);
      end
      chk($sformatf("vec%0d issue_ready", i), 32'(issue_ready), 32'(vq[i].eir));
      chk($sformatf("vec%0d busy", i), busy, vq[i].eb);
      tick();
    end

    // Scoreboard saturation, blocked issue, commit release, simultaneous inc/dec on r7
    drive(3'b000, 15'h0, 32'h0, 1'b1, 5'd7);
    #1 chk("sb issue1 ready", 32'(issue_ready), 32'd1);
    tick();
    #1 chk("sb busy after 1", busy, 32'h80);
    tick();
    #1 chk("sb issue3 ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    #1 chk("sb r7 saturated", 32'(issue_ready), 32'd0);
    chk("sb busy sat", busy, 32'h80);
    issue_waddr = 5'd8;
    #1 chk("sb r8 ready", 32'(issue_ready), 32'd1);
    drive(3'b000, 15'h0, 32'h0, 1'b1, 5'd7);
    #1 chk("sb blocked issue", 32'(issue_ready), 32'd0);
    tick();
    drive(3'b001, 15'd7, 32'h7777, 1'b0, 5'd7);
    #1 chk("sb commit grant", 32'(req_ready), 32'b001);
    chk("sb no wrap", busy, 32'h80);
    tick();
    drive(3'b000, 15'h0, 32'h0, 1'b0, 5'd7);
    #1 chk("sb commit wen", 32'(wen), 32'd1);
    chk("sb commit waddr", 32'(waddr), 32'd7);
    chk("sb commit wdata", wdata, 32'h7777);
    chk("sb still sat", 32'(issue_ready), 32'd0);
    tick();
    #1 chk("sb released", 32'(issue_ready), 32'd1);
    chk("sb wen drop", 32'(wen), 32'd0);
    drive(3'b001, 15'd7, 32'h8888, 1'b0, 5'd7);
    #1 chk("sb commit2 grant", 32'(req_ready), 32'b001);
    tick();
    drive(3'b000, 15'h0, 32'h0, 1'b1, 5'd7);
    #1 chk("sb inc+dec wen", 32'(wen), 32'd1);
    chk("sb inc+dec ready", 32'(issue_ready), 32'd1);
    tick();
    issue_valid = 1'b0;
    #1 chk("sb count kept busy", busy, 32'h80);
    chk("sb count kept ready", 32'(issue_ready), 32'd1);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    #1 chk("sb count was 2", 32'(issue_ready), 32'd0);

    // Reset in the middle of a write stream
    do_reset();
    drive(3'b000, 15'h0, 32'h0, 1'b1, 5'd1);
    tick();
    issue_waddr = 5'd2;
    tick();
    drive(3'b111, A123, 32'h200, 1'b0, 5'd0);
    #1 chk("rs grant0", 32'(req_ready), 32'b001);
    tick();
    #1 chk("rs grant1", 32'(req_ready), 32'b010);
    chk("rs wen", 32'(wen), 32'd1);
    chk("rs waddr", 32'(waddr), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(3'b111, 15'h0, 32'h0, 1'b0, 5'd2);
    #1 chk("rs wen dropped", 32'(wen), 32'd0);
    chk("rs busy clear", busy, 32'h0);
    chk("rs issue_ready", 32'(issue_ready), 32'd1);
    chk("rs restart 0", 32'(req_ready), 32'b001);
    tick();
    #1 chk("rs restart 1", 32'(req_ready), 32'b010);
    tick();
    #1 chk("rs restart 2", 32'(req_ready), 32'b100);
    tick();

    // Randomized traffic against the reference model
    do_reset();
    m_ptr   = 0;
    m_wen   = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    for (int i = 0; i < 32; i++) begin
      m_cnt[i] = 0;
      alloc[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      hv[i] = 1'b0;
      ha[i] = '0;
      hd[i] = '0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 3; i++) begin
        req_valid[i]          = hv[i];
        req_waddr[5*i +: 5]   = ha[i];
        req_wdata[32*i +: 32] = hd[i];
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_waddr = 5'($urandom_range(0, 7));
      #1;
      g = -1;
      for (int k = 0; k < 3; k++) begin
        idx = (m_ptr + k) % 3;
        if (g < 0 && hv[idx]) g = idx;
      end
      exp_rdy  = (g >= 0) ? 3'(1 << g) : 3'b000;
      exp_ir   = (issue_waddr == 5'd0) || (m_cnt[issue_waddr] < 3);
      exp_busy = '0;
      for (int k = 1; k < 32; k++) exp_busy[k] = (m_cnt[k] != 0);
      chk($sformatf("rnd%0d req_ready", cyc), 32'(req_ready), 32'(exp_rdy));
      chk($sformatf("rnd%0d issue_ready", cyc), 32'(issue_ready), 32'(exp_ir));
      chk($sformatf("rnd%0d busy", cyc), busy, exp_busy);
      chk($sformatf("rnd%0d wen", cyc), 32'(wen), 32'(m_wen));
      chk($sformatf("rnd%0d waddr", cyc), 32'(waddr), 32'(m_waddr));
      chk($sformatf("rnd%0d wdata", cyc), wdata, m_wdata);
      tick();
      if (m_wen && m_cnt[m_waddr] > 0) m_cnt[m_waddr]--;
      if (issue_valid && exp_ir && issue_waddr != 5'd0) begin
        m_cnt[issue_waddr]++;
        alloc[issue_waddr]++;
      end
      if (g >= 0) begin
        m_wen   = (ha[g] != 5'd0);
        m_waddr = ha[g];
        m_wdata = hd[g];
        m_ptr   = (g + 1) % 3;
        hv[g]   = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      // New requests only target registers that have an issued, unclaimed write
      for (int i = 0; i < 3; i++) begin
        if (!hv[i] && $urandom_range(0, 3) != 0) begin
          r = int'($urandom_range(0, 7));
          if (r == 0 || alloc[r] > 0) begin
            if (r != 0) alloc[r]--;
            hv[i] = 1'b1;
            ha[i] = 5'(r);
            hd[i] = $urandom;
          end
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
